// File: rtl/caparray_s2_pkg.sv
// Shared constants for the stage-2 cap-array controller: field widths,
// config addresses and the ramp FSM state encoding.
package caparray_s2_pkg;

  localparam int unsigned SHUNT_W       = 11;
  localparam int unsigned SHUNT_GY_W    = 5;
  localparam int unsigned SERIES_GY_W   = 8;
  localparam int unsigned SERIES_GYGY_W = 8;

  localparam logic [1:0] ADDR_SHUNT       = 2'd0;
  localparam logic [1:0] ADDR_SHUNT_GY    = 2'd1;
  localparam logic [1:0] ADDR_SERIES_GY   = 2'd2;
  localparam logic [1:0] ADDR_SERIES_GYGY = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RAMP   = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

endpackage

// File: rtl/caparray_ramp_step.sv
// One tune field: on each step, moves the live code one LSB toward the
// target (or loads it outright when jump is set). Never overshoots or wraps.
module caparray_ramp_step #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         step,
  input  logic         jump,
  input  logic [W-1:0] target,
  output logic [W-1:0] live,
  output logic         eq
);

  always_ff @(posedge clk) begin
    if (rst) begin
      live <= '0;
    end else if (step) begin
      if (jump)
        live <= target;
      else if (live < target)
        live <= live + W'(1);
      else if (live > target)
        live <= live - W'(1);
    end
  end

  assign eq = (live == target);

endmodule

// File: rtl/caparray_s2_ctrl.sv
// Stage-2 cap-array control: shadow registers behind a valid/ready config
// port, and a commit-triggered slew-limited ramp of the four live tune words.
module caparray_s2_ctrl
  import caparray_s2_pkg::*;
#(
  parameter int unsigned STEP_DIV = 16,
  parameter bit          RAMP_EN  = 1'b1
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [1:0]  cfg_addr,
  input  logic [10:0] cfg_data,
  input  logic        commit,
  output logic        busy,
  output logic        done,
  output logic [10:0] tune_shunt,
  output logic [4:0]  tune_shunt_gy,
  output logic [7:0]  tune_series_gy,
  output logic [7:0]  tune_series_gygy
);

  localparam logic [15:0] DIV_LAST = 16'(STEP_DIV - 1);

  state_t      state;
  logic [15:0] div;

  logic [SHUNT_W-1:0]       sh_shunt,       sh_shunt_nxt,       tgt_shunt;
  logic [SHUNT_GY_W-1:0]    sh_shunt_gy,    sh_shunt_gy_nxt,    tgt_shunt_gy;
  logic [SERIES_GY_W-1:0]   sh_series_gy,   sh_series_gy_nxt,   tgt_series_gy;
  logic [SERIES_GYGY_W-1:0] sh_series_gygy, sh_series_gygy_nxt, tgt_series_gygy;

  logic wr, step, jump, all_eq;
  logic eq_shunt, eq_shunt_gy, eq_series_gy, eq_series_gygy;

  assign cfg_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_FINISH);
  assign wr        = cfg_valid & cfg_ready;
  assign step      = (state == ST_RAMP) && (div == DIV_LAST);
  assign jump      = ~RAMP_EN;
  assign all_eq    = eq_shunt & eq_shunt_gy & eq_series_gy & eq_series_gygy;

  // Forwarded shadow values so a write in the commit cycle lands in the target.
  always_comb begin
    sh_shunt_nxt       = sh_shunt;
    sh_shunt_gy_nxt    = sh_shunt_gy;
    sh_series_gy_nxt   = sh_series_gy;
    sh_series_gygy_nxt = sh_series_gygy;
    if (wr) begin
      case (cfg_addr)
        ADDR_SHUNT:       sh_shunt_nxt       = cfg_data[SHUNT_W-1:0];
        ADDR_SHUNT_GY:    sh_shunt_gy_nxt    = cfg_data[SHUNT_GY_W-1:0];
        ADDR_SERIES_GY:   sh_series_gy_nxt   = cfg_data[SERIES_GY_W-1:0];
        ADDR_SERIES_GYGY: sh_series_gygy_nxt = cfg_data[SERIES_GYGY_W-1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state           <= ST_IDLE;
      div             <= '0;
      sh_shunt        <= '0;
      sh_shunt_gy     <= '0;
      sh_series_gy    <= '0;
      sh_series_gygy  <= '0;
      tgt_shunt       <= '0;
      tgt_shunt_gy    <= '0;
      tgt_series_gy   <= '0;
      tgt_series_gygy <= '0;
    end else begin
      sh_shunt       <= sh_shunt_nxt;
      sh_shunt_gy    <= sh_shunt_gy_nxt;
      sh_series_gy   <= sh_series_gy_nxt;
      sh_series_gygy <= sh_series_gygy_nxt;
      case (state)
        ST_IDLE: begin
          if (commit) begin
            tgt_shunt       <= sh_shunt_nxt;
            tgt_shunt_gy    <= sh_shunt_gy_nxt;
            tgt_series_gy   <= sh_series_gy_nxt;
            tgt_series_gygy <= sh_series_gygy_nxt;
            div             <= '0;
            state           <= ST_RAMP;
          end
        end
        ST_RAMP: begin
          if (all_eq)
            state <= ST_FINISH;
          else
            div <= (div == DIV_LAST) ? '0 : div + 16'd1;
        end
        ST_FINISH: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  caparray_ramp_step #(.W(SHUNT_W)) u_shunt (
    .clk(wb_clk_i), .rst(wb_rst_i), .step(step), .jump(jump),
    .target(tgt_shunt), .live(tune_shunt), .eq(eq_shunt)
  );

  caparray_ramp_step #(.W(SHUNT_GY_W)) u_shunt_gy (
    .clk(wb_clk_i), .rst(wb_rst_i), .step(step), .jump(jump),
    .target(tgt_shunt_gy), .live(tune_shunt_gy), .eq(eq_shunt_gy)
  );

  caparray_ramp_step #(.W(SERIES_GY_W)) u_series_gy (
    .clk(wb_clk_i), .rst(wb_rst_i), .step(step), .jump(jump),
    .target(tgt_series_gy), .live(tune_series_gy), .eq(eq_series_gy)
  );

  caparray_ramp_step #(.W(SERIES_GYGY_W)) u_series_gygy (
    .clk(wb_clk_i), .rst(wb_rst_i), .step(step), .jump(jump),
    .target(tgt_series_gygy), .live(tune_series_gygy), .eq(eq_series_gygy)
  );

endmodule

// File: tb/tb_caparray_s2_ctrl.sv
// Directed bench for caparray_s2_ctrl: three builds (STEP_DIV=4, STEP_DIV=1,
// and STEP_DIV=4 with RAMP_EN=0), each with its own stimulus set.
module tb_caparray_s2_ctrl;

  logic clk;
  logic        rst       [3];
  logic        cfg_valid [3];
  logic [1:0]  cfg_addr  [3];
  logic [10:0] cfg_data  [3];
  logic        commit    [3];
  logic        cfg_ready [3];
  logic        busy      [3];
  logic        done      [3];
  logic [10:0] ts        [3];
  logic [4:0]  tsg       [3];
  logic [7:0]  tsgy      [3];
  logic [7:0]  tsgygy    [3];

  int n_tests = 0;
  int n_fail  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  caparray_s2_ctrl #(.STEP_DIV(4), .RAMP_EN(1'b1)) u_div4 (
    .wb_clk_i(clk), .wb_rst_i(rst[0]), .cfg_valid(cfg_valid[0]), .cfg_ready(cfg_ready[0]),
    .cfg_addr(cfg_addr[0]), .cfg_data(cfg_data[0]), .commit(commit[0]),
    .busy(busy[0]), .done(done[0]), .tune_shunt(ts[0]), .tune_shunt_gy(tsg[0]),
    .tune_series_gy(tsgy[0]), .tune_series_gygy(tsgygy[0])
  );

  caparray_s2_ctrl #(.STEP_DIV(1), .RAMP_EN(1'b1)) u_div1 (
    .wb_clk_i(clk), .wb_rst_i(rst[1]), .cfg_valid(cfg_valid[1]), .cfg_ready(cfg_ready[1]),
    .cfg_addr(cfg_addr[1]), .cfg_data(cfg_data[1]), .commit(commit[1]),
    .busy(busy[1]), .done(done[1]), .tune_shunt(ts[1]), .tune_shunt_gy(tsg[1]),
    .tune_series_gy(tsgy[1]), .tune_series_gygy(tsgygy[1])
  );

  caparray_s2_ctrl #(.STEP_DIV(4), .RAMP_EN(1'b0)) u_jump (
    .wb_clk_i(clk), .wb_rst_i(rst[2]), .cfg_valid(cfg_valid[2]), .cfg_ready(cfg_ready[2]),
    .cfg_addr(cfg_addr[2]), .cfg_data(cfg_data[2]), .commit(commit[2]),
    .busy(busy[2]), .done(done[2]), .tune_shunt(ts[2]), .tune_shunt_gy(tsg[2]),
    .tune_series_gy(tsgy[2]), .tune_series_gygy(tsgygy[2])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cfg_write(input int k, input logic [1:0] addr, input logic [10:0] data);
    @(negedge clk);
    cfg_valid[k] = 1'b1;
    cfg_addr[k]  = addr;
    cfg_data[k]  = data;
    @(negedge clk);
    cfg_valid[k] = 1'b0;
  endtask

  // Returns at the sample just after the commit edge.
  task automatic do_commit(input int k);
    @(negedge clk);
    commit[k] = 1'b1;
    @(negedge clk);
    commit[k] = 1'b0;
  endtask

  task automatic run_to_idle(input int k, output int cyc, output int nd);
    cyc = 0;
    nd  = 0;
    while (busy[k] && cyc < 1000) begin
      cyc++;
      if (done[k]) nd++;
      @(negedge clk);
    end
    check("idle_timeout", 32'(cyc < 1000), 1);
  endtask

  initial begin
    int cyc, nd, c, nchg;
    logic [10:0] prev;

    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; cfg_valid[i] = 1'b0; cfg_addr[i] = '0;
      cfg_data[i] = '0; commit[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;

    check("rst_shunt", 32'(ts[0]), 0);
    check("rst_busy", 32'(busy[0]), 0);
    check("rst_done", 32'(done[0]), 0);
    check("rst_ready", 32'(cfg_ready[0]), 1);

    // Test 1: shunt 0 -> 3 at STEP_DIV=4
    cfg_write(0, 2'd0, 11'd3);
    do_commit(0);
    c = 0; nchg = 0; prev = '0; cyc = 0; nd = 0;
    while (busy[0] && c < 200) begin
      cyc++;
      if (done[0]) nd++;
      if (ts[0] != prev) begin
        nchg++;
        check("t1_step_cycle", 32'(c), 32'(4 * nchg));
        check("t1_step_value", 32'(ts[0]), 32'(nchg));
        prev = ts[0];
      end
      @(negedge clk);
      c++;
    end
    check("t1_busy_cycles", 32'(cyc), 14);
    check("t1_done_pulses", 32'(nd), 1);
    check("t1_nsteps", 32'(nchg), 3);
    check("t1_shunt_gy", 32'(tsg[0]), 0);
    check("t1_series_gy", 32'(tsgy[0]), 0);
    check("t1_series_gygy", 32'(tsgygy[0]), 0);

    // Test 2: truncation and ramp down to zero
    cfg_write(0, 2'd1, 11'h7FF);
    do_commit(0);
    run_to_idle(0, cyc, nd);
    check("t2_up_cycles", 32'(cyc), 126);
    check("t2_up_done", 32'(nd), 1);
    check("t2_up_gy", 32'(tsg[0]), 31);
    check("t2_up_shunt", 32'(ts[0]), 3);
    cfg_write(0, 2'd1, 11'd0);
    do_commit(0);
    run_to_idle(0, cyc, nd);
    check("t2_dn_cycles", 32'(cyc), 126);
    check("t2_dn_gy", 32'(tsg[0]), 0);

    // Test 3: four fields in parallel at STEP_DIV=1
    cfg_write(1, 2'd0, 11'd5);
    cfg_write(1, 2'd1, 11'd2);
    cfg_write(1, 2'd2, 11'd8);
    cfg_write(1, 2'd3, 11'd1);
    do_commit(1);
    @(negedge clk);
    check("t3_e1_shunt", 32'(ts[1]), 1);
    check("t3_e1_gygy", 32'(tsgygy[1]), 1);
    @(negedge clk);
    check("t3_e2_shunt", 32'(ts[1]), 2);
    check("t3_e2_gy", 32'(tsg[1]), 2);
    check("t3_e2_sgy", 32'(tsgy[1]), 2);
    check("t3_e2_gygy", 32'(tsgygy[1]), 1);
    run_to_idle(1, cyc, nd);
    check("t3_rest_cycles", 32'(cyc), 8);
    check("t3_done", 32'(nd), 1);
    check("t3_shunt", 32'(ts[1]), 5);
    check("t3_gy", 32'(tsg[1]), 2);
    check("t3_sgy", 32'(tsgy[1]), 8);
    check("t3_gygy", 32'(tsgygy[1]), 1);

    // Test 4: write+commit same cycle, then writes/commits while busy
    @(negedge clk);
    cfg_valid[0] = 1'b1; cfg_addr[0] = 2'd2; cfg_data[0] = 11'd10; commit[0] = 1'b1;
    @(negedge clk);
    check("t4_busy", 32'(busy[0]), 1);
    check("t4_ready_busy", 32'(cfg_ready[0]), 0);
    cfg_data[0] = 11'd200;
    repeat (3) @(negedge clk);
    check("t4_ready_held", 32'(cfg_ready[0]), 0);
    cfg_valid[0] = 1'b0; commit[0] = 1'b0;
    run_to_idle(0, cyc, nd);
    check("t4_done", 32'(nd), 1);
    check("t4_sgy", 32'(tsgy[0]), 10);
    check("t4_shunt", 32'(ts[0]), 3);
    repeat (3) @(negedge clk);
    check("t4_no_rerun", 32'(busy[0]), 0);

    // Test 5: commit with targets already equal to live values
    do_commit(0);
    run_to_idle(0, cyc, nd);
    check("t5_busy_cycles", 32'(cyc), 2);
    check("t5_done", 32'(nd), 1);
    check("t5_shunt", 32'(ts[0]), 3);
    check("t5_sgy", 32'(tsgy[0]), 10);

    // Test 6: reset mid-ramp at shunt = 40 of 100
    cfg_write(0, 2'd0, 11'd100);
    do_commit(0);
    c = 0;
    while (ts[0] != 11'd40 && c < 1000) begin
      @(negedge clk);
      c++;
    end
    check("t6_reach40", 32'(ts[0]), 40);
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    check("t6_shunt", 32'(ts[0]), 0);
    check("t6_sgy", 32'(tsgy[0]), 0);
    check("t6_busy", 32'(busy[0]), 0);
    check("t6_done", 32'(done[0]), 0);
    check("t6_ready", 32'(cfg_ready[0]), 1);
    nd = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done[0] || busy[0]) nd++;
    end
    check("t6_quiet", 32'(nd), 0);

    // RAMP_EN=0: target loaded on the first step edge
    cfg_write(2, 2'd0, 11'd100);
    do_commit(2);
    repeat (3) @(negedge clk);
    check("t6j_pre", 32'(ts[2]), 0);
    @(negedge clk);
    check("t6j_load", 32'(ts[2]), 100);
    run_to_idle(2, cyc, nd);
    check("t6j_tail", 32'(cyc), 2);
    check("t6j_done", 32'(nd), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/caparray_s2_ctrl.md
Name: caparray_s2_ctrl

Overview:
Control-side counterpart of the stage-2 tunable capacitor array. Drives the four tune words: tune_shunt, tune_shunt_gy, tune_series_gy and tune_series_gygy.
- Firmware writes target codes into shadow registers through a valid/ready config port.
- A commit then moves the live tune outputs toward the targets, one LSB per step, so the filter never sees a large step in capacitance.
- Sits between the user-project config logic and the cap-array instance.

Parameters:
STEP_DIV, 16, clock cycles per ramp step (legal range 1..65535).
RAMP_EN, 1, 1 = slew-limited ramp; 0 = live outputs load targets in a single step.

Ports:
wb_clk_i  in  1  system clock
wb_rst_i  in  1  synchronous active-high reset
cfg_valid  in  1  config write request
cfg_ready  out  1  config write accepted when high with cfg_valid
cfg_addr  in  2  field select: 0 shunt, 1 shunt_gy, 2 series_gy, 3 series_gygy
cfg_data  in  11  shadow value, LSB-aligned
commit  in  1  single-cycle request to apply the shadows
busy  out  1  ramp in progress
done  out  1  one-cycle pulse when the ramp completes
tune_shunt  out  11  live code to the cap array
tune_shunt_gy  out  5  live code to the cap array
tune_series_gy  out  8  live code to the cap array
tune_series_gygy  out  8  live code to the cap array

Behaviour:
- Clocking and reset: single clock wb_clk_i; synchronous active-high reset wb_rst_i.
- Reset values: all shadows, targets and live tune outputs 0; busy 0; done 0; cfg_ready 1; FSM IDLE; divider 0.
- Reset mid-ramp: on the next edge all live outputs return to 0 and the ramp is abandoned; no done pulse.
- FSM states: IDLE, RAMP, FINISH.
- Config write:
  - A write occurs on an edge where cfg_valid & cfg_ready.
  - cfg_data is truncated to the field width (upper bits ignored); the shadow updates on that edge.
  - cfg_ready = (state == IDLE).
- IDLE -> RAMP:
  - Taken on commit in IDLE.
  - Targets load from the shadows on the same edge, including any write accepted in that cycle (the write takes precedence into the target).
  - Divider clears to 0.
- commit while busy: ignored, not queued.
- RAMP stepping:
  - Divider counts 0..STEP_DIV-1.
  - On the edge where divider == STEP_DIV-1, every field whose live value differs from its target moves exactly 1 toward it; all four fields step in parallel.
  - Divider then wraps to 0.
  - Unsigned compare per field; no overshoot; no wrap.
- RAMP -> FINISH: taken on the first cycle in RAMP in which all four live values equal their targets (combinational check). This includes the first RAMP cycle when targets already equal the live values.
- FINISH -> IDLE: one cycle. done = 1 only in FINISH.
- busy = (state != IDLE), so busy is high in RAMP and FINISH.
- Live outputs are registered and change only on step edges or at reset.
- Ramp duration: N_max * STEP_DIV cycles in RAMP, where N_max is the largest |target - live| across fields. Then 1 cycle in RAMP with the equality check, then FINISH.
- RAMP_EN = 0: the first step edge (divider == STEP_DIV-1) loads all targets directly, then the normal FINISH sequence follows.
- STEP_DIV = 1: a step occurs every RAMP cycle.
- Shadows remain writable only in IDLE, so targets are stable during a ramp.

Decomposition:
- Package caparray_s2_pkg:
  - field widths: SHUNT_W = 11, SHUNT_GY_W = 5, SERIES_GY_W = 8, SERIES_GYGY_W = 8;
  - address constants ADDR_SHUNT = 0, ADDR_SHUNT_GY = 1, ADDR_SERIES_GY = 2, ADDR_SERIES_GYGY = 3;
  - FSM state encoding.
- One sub-module, caparray_ramp_step:
  - parameter W;
  - inputs: step, jump, target[W-1:0];
  - output: live[W-1:0];
  - output eq = (live == target);
  - synchronous reset to 0;
  - instantiated four times.
- Top holds the FSM, divider, shadows and config decode.

Test Plan:
1. Reset, STEP_DIV = 4. Write addr0 = 3, then commit.
   -> tune_shunt goes 1, 2, 3 at 4-cycle intervals after commit.
   -> busy high 14 cycles (12 RAMP stepping + 1 RAMP equality check + 1 FINISH).
   -> done pulses once; other outputs stay 0.
2. Write shunt_gy = 0x1F with cfg_data = 0x7FF, then commit.
   -> Upper bits truncated; tune_shunt_gy ramps to 31.
   -> Then write 0 and commit; tune_shunt_gy ramps down to 0 with no underflow.
3. Parallel fields: targets 5 / 2 / 8 / 1, STEP_DIV = 1.
   -> All fields step together; each stops at its own target.
   -> done occurs after 8 step edges, when series_gy = 8.
4. Handshake during ramp: cfg_valid and commit asserted while busy.
   -> cfg_ready = 0; shadows and targets are unchanged; no second ramp starts.
   -> A write in the same cycle as a commit in IDLE lands in the target.
5. Commit with targets equal to the live values.
   -> busy high exactly 2 cycles; done pulses; outputs unchanged.
6. wb_rst_i asserted mid-ramp at tune_shunt = 40 of 100.
   -> Next edge: all outputs 0, busy 0, no done.
   -> RAMP_EN = 0 build: commit of 100 loads 100 on the first step edge.
